rr_arbiter8: RTL and testbench

RR_ARBITER8 -- requirements
Module: rr_arbiter8

---
 rtl/rr_arbiter8_pkg.sv | 17 +
 rtl/rr_arbiter8_if.sv | 26 ++
 rtl/rr_pick.sv | 36 +++
 rtl/rr_arbiter8.sv | 97 +++++++++
 tb/tb_rr_arbiter8.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/rr_arbiter8_pkg.sv
// rtl/rr_arbiter8_pkg.sv - shared constants and state encoding for the round-robin arbiter
package rr_arbiter8_pkg;

  localparam int DEF_N       = 8;
  localparam int DEF_MAXHOLD = 15;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Width of an index into an n-wide vector; never zero so ports stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// rtl/rr_arbiter8_if.sv - request/grant bundle between requesters and the arbiter
interface rr_arbiter8_if #(
  parameter int N = rr_arbiter8_pkg::DEF_N
);
  logic [N-1:0] req;
  logic         done;
  logic [N-1:0] grant;
  logic         busy;
  logic         timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  busy,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output busy,
    output timeout
  );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotate-and-find-first: first set req bit at or above ptr, wrapping
module rr_pick
  import rr_arbiter8_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int PW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] idx,
  output logic          valid
);

  logic [PW:0]   sum;
  logic [PW-1:0] pos;

  always_comb begin
    pick  = '0;
    idx   = '0;
    valid = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      pos = sum[PW-1:0];
      if (!valid && req[pos]) begin
        valid     = 1'b1;
        pick[pos] = 1'b1;
        idx       = pos;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - round-robin arbiter with registered one-hot grant and hold timeout
module rr_arbiter8
  import rr_arbiter8_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int MAXHOLD = DEF_MAXHOLD
) (
  input logic          clk,
  input logic          rst_n,
  rr_arbiter8_if.slave bus
);

  localparam int PW = idx_width(N);
  localparam int CW = $clog2(MAXHOLD + 1);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  logic [N-1:0]  pick;
  logic [PW-1:0] pick_idx;
  logic          pick_valid;
  logic          at_limit;
  logic          owner_req;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .pick  (pick),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign at_limit  = (cnt_q == CW'(MAXHOLD));
  assign owner_req = bus.req[owner_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      owner_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      owner_q   <= owner_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    owner_d   = owner_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = HOLD;
          grant_d = pick;
          owner_d = pick_idx;
          cnt_d   = CW'(1);
        end
      end
      HOLD: begin
        if (bus.done || !owner_req || at_limit) begin
          state_d   = IDLE;
          grant_d   = '0;
          cnt_d     = '0;
          ptr_d     = (owner_q == PW'(N - 1)) ? '0 : owner_q + PW'(1);
          // Only a pure counter expiry counts as a forced release.
          timeout_d = at_limit && !bus.done && owner_req;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = (state_q == HOLD);
  assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed self-checking bench for rr_arbiter8
module tb_rr_arbiter8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rr_arbiter8_if #(.N(8)) bus ();

  rr_arbiter8 #(.N(8), .MAXHOLD(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] g, input logic t);
    check({tag, "_grant"}, 32'(bus.grant), 32'(g));
    check({tag, "_busy"}, 32'(bus.busy), 32'(g != 8'h00));
    check({tag, "_timeout"}, 32'(bus.timeout), 32'(t));
  endtask

  // One-hot and busy/grant consistency are watched every cycle.
  always @(negedge clk) begin
    check("onehot0", 32'($onehot0(bus.grant)), 32'd1);
    check("busy_vs_grant", 32'(bus.busy), 32'(bus.grant != 8'h00));
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.req  = 8'h00;
    bus.done = 1'b0;
    #1;
    expect_out("reset", 8'h00, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    expect_out("idle_noreq", 8'h00, 1'b0);

    // Single requester, done on the third hold cycle.
    bus.req = 8'b0000_0100;
    step();
    expect_out("single_c1", 8'h04, 1'b0);
    step();
    expect_out("single_c2", 8'h04, 1'b0);
    step();
    expect_out("single_c3", 8'h04, 1'b0);
    bus.done = 1'b1;
    step();
    expect_out("single_rel", 8'h00, 1'b0);

    // ptr is now 3: everyone requests, done held high (ignored while idle).
    bus.req = 8'hFF;
    step();
    expect_out("rot_first", 8'h08, 1'b0);
    for (int k = 1; k <= 9; k++) begin
      step();
      expect_out("rot_bubble", 8'h00, 1'b0);
      step();
      expect_out("rot_grant", 8'(1 << ((3 + k) % 8)), 1'b0);
    end
    // Last owner was 4; dropping its request releases it (ptr -> 5).
    bus.done = 1'b0;
    bus.req  = 8'h00;
    step();
    expect_out("rot_drop", 8'h00, 1'b0);

    // Wrap: owner 6 released by request drop, ptr 7, then 0.
    bus.req = 8'h40;
    step();
    expect_out("wrap_g6", 8'h40, 1'b0);
    bus.req = 8'b1000_0001;
    step();
    expect_out("wrap_drop6", 8'h00, 1'b0);
    step();
    expect_out("wrap_g7", 8'h80, 1'b0);
    bus.done = 1'b1;
    step();
    expect_out("wrap_rel7", 8'h00, 1'b0);
    bus.done = 1'b0;
    step();
    expect_out("wrap_g0", 8'h01, 1'b0);
    bus.req = 8'h00;
    step();
    expect_out("wrap_rel0", 8'h00, 1'b0);

    // Timeout: held 15 cycles, pulse on the release cycle only, then regrant.
    bus.req = 8'h10;
    step();
    expect_out("to_c1", 8'h10, 1'b0);
    for (int k = 2; k <= 15; k++) begin
      step();
      expect_out("to_hold", 8'h10, 1'b0);
    end
    step();
    expect_out("to_release", 8'h00, 1'b1);
    step();
    expect_out("to_regrant", 8'h10, 1'b0);

    // done coinciding with the counter limit: no timeout pulse.
    for (int k = 2; k <= 15; k++) step();
    expect_out("sim_c15", 8'h10, 1'b0);
    bus.done = 1'b1;
    step();
    expect_out("sim_release", 8'h00, 1'b0);
    bus.done = 1'b0;

    // Owner request drops mid-hold.
    step();
    expect_out("drop_c1", 8'h10, 1'b0);
    step();
    bus.req = 8'h00;
    step();
    expect_out("drop_rel", 8'h00, 1'b0);

    // Asynchronous reset between edges while holding.
    bus.req = 8'h10;
    step();
    expect_out("ar_c1", 8'h10, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("ar_async", 8'h00, 1'b0);
    step();
    expect_out("ar_held", 8'h00, 1'b0);
    rst_n = 1'b1;
    step();
    expect_out("ar_first_arb", 8'h10, 1'b0);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
